// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for the data memory: the MEM-stage core port has priority,
// and the UART host port is served after STARVE_LIMIT consecutive core grants.
module data_mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              user_req,
  input  logic              user_we,
  input  logic [ADDR_W-1:0] user_addr,
  input  logic [DATA_W-1:0] user_wdata,
  output logic              user_gnt,
  output logic              user_rvalid,
  output logic [DATA_W-1:0] user_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, CORE, USER} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            state_reg, state_next;
  logic [3:0]        starve_cnt_reg;
  logic              rd_pending_reg;
  logic [DATA_W-1:0] core_rdata_reg, user_rdata_reg;
  logic              starved;

  assign starved = (starve_cnt_reg == LIMIT);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    if (core_gnt)      state_next = CORE;
    else if (user_gnt) state_next = USER;
  end

  // The state holds last cycle's owner, so it doubles as the owner field of the read tag.
  always_comb begin
    core_gnt    = 1'b0;
    user_gnt    = 1'b0;
    core_rvalid = 1'b0;
    user_rvalid = 1'b0;
    if (!rst) begin
      core_gnt    = core_req & ~(user_req & starved);
      user_gnt    = user_req & (~core_req | starved);
      core_rvalid = rd_pending_reg & (state_reg == CORE);
      user_rvalid = rd_pending_reg & (state_reg == USER);
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (user_gnt) begin
      mem_we    = user_we;
      mem_addr  = user_addr;
      mem_wdata = user_wdata;
    end
  end

  assign mem_en     = core_gnt | user_gnt;
  assign core_stall = core_req & ~core_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_reg <= 4'd0;
      rd_pending_reg <= 1'b0;
      core_rdata_reg <= '0;
      user_rdata_reg <= '0;
    end else begin
      rd_pending_reg <= mem_en & ~mem_we;
      if (user_gnt || !user_req)
        starve_cnt_reg <= 4'd0;
      else if (core_gnt && starve_cnt_reg < LIMIT)
        starve_cnt_reg <= starve_cnt_reg + 4'd1;
      if (core_rvalid) core_rdata_reg <= mem_rdata;
      if (user_rvalid) user_rdata_reg <= mem_rdata;
    end
  end

  // Read data flows through in the rvalid cycle and is held afterwards.
  assign core_rdata = core_rvalid ? mem_rdata : core_rdata_reg;
  assign user_rdata = user_rvalid ? mem_rdata : user_rdata_reg;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: a one-cycle-latency memory model,
// hand-computed grant patterns, read returns and reset behaviour.
module tb_data_mem_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic              core_req, core_we, user_req, user_we;
  logic [ADDR_W-1:0] core_addr, user_addr;
  logic [DATA_W-1:0] core_wdata, user_wdata;
  logic              core_gnt, core_stall, core_rvalid, user_gnt, user_rvalid;
  logic [DATA_W-1:0] core_rdata, user_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .user_req(user_req), .user_we(user_we), .user_addr(user_addr), .user_wdata(user_wdata),
    .user_gnt(user_gnt), .user_rvalid(user_rvalid), .user_rdata(user_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: address 0x0010 holds A5 bytes, every other address holds its address replicated.
  always @(posedge clk) begin
    if (mem_en && !mem_we)
      mem_rdata <= (mem_addr == 16'h0010) ? {16{8'hA5}} : {8{mem_addr}};
  end

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic creq, input logic cwe, input logic [15:0] caddr,
                       input logic ureq, input logic uwe, input logic [15:0] uaddr,
                       input logic [DATA_W-1:0] uwd);
    core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = '0;
    user_req = ureq; user_we = uwe; user_addr = uaddr; user_wdata = uwd;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mem_rdata = '0;
    rst = 1'b1;
    drive(1, 0, 16'h0001, 1, 0, 16'h0002, '0);
    to_neg();
    check("rst_core_gnt", 128'(core_gnt), 128'(0));
    check("rst_user_gnt", 128'(user_gnt), 128'(0));
    check("rst_mem_en", 128'(mem_en), 128'(0));
    to_next();
    to_neg();
    check("rst_core_rdata", core_rdata, '0);
    check("rst_starve", 128'(dut.starve_cnt_reg), 128'(0));
    to_next();
    rst = 1'b0;

    // Core-only read of 0x0010.
    drive(1, 0, 16'h0010, 0, 0, 16'h0000, '0);
    to_neg();
    $display("core read 0x0010: gnt=%0b", core_gnt);
    check("t1_core_gnt", 128'(core_gnt), 128'(1));
    check("t1_user_gnt", 128'(user_gnt), 128'(0));
    check("t1_mem_addr", 128'(mem_addr), 128'h10);
    check("t1_mem_we", 128'(mem_we), 128'(0));
    to_next();
    drive(0, 0, 16'h0000, 0, 0, 16'h0000, '0);
    to_neg();
    check("t1_core_rvalid", 128'(core_rvalid), 128'(1));
    check("t1_core_rdata", core_rdata, {16{8'hA5}});
    check("t1_user_rvalid", 128'(user_rvalid), 128'(0));
    to_next();

    // User write 0x1234 to 0x0003.
    drive(0, 0, 16'h0000, 1, 1, 16'h0003, 128'h1234);
    to_neg();
    $display("user write 0x0003: gnt=%0b we=%0b", user_gnt, mem_we);
    check("t3_user_gnt", 128'(user_gnt), 128'(1));
    check("t3_mem_we", 128'(mem_we), 128'(1));
    check("t3_mem_addr", 128'(mem_addr), 128'h3);
    check("t3_mem_wdata", mem_wdata, 128'h1234);
    to_next();
    drive(0, 0, 16'h0000, 0, 0, 16'h0000, '0);
    to_neg();
    check("t3_core_rvalid", 128'(core_rvalid), 128'(0));
    check("t3_user_rvalid", 128'(user_rvalid), 128'(0));
    check("t3_core_rdata_hold", core_rdata, {16{8'hA5}});
    to_next();

    // Core read then user read on consecutive cycles.
    drive(1, 0, 16'h0020, 0, 0, 16'h0000, '0);
    to_neg();
    check("t4_core_gnt", 128'(core_gnt), 128'(1));
    to_next();
    drive(0, 0, 16'h0000, 1, 0, 16'h0030, '0);
    to_neg();
    $display("core/user reads: core_rvalid=%0b user_gnt=%0b", core_rvalid, user_gnt);
    check("t4_user_gnt", 128'(user_gnt), 128'(1));
    check("t4_core_rvalid", 128'(core_rvalid), 128'(1));
    check("t4_core_rdata", core_rdata, {8{16'h0020}});
    to_next();
    drive(0, 0, 16'h0000, 0, 0, 16'h0000, '0);
    to_neg();
    check("t4_user_rvalid", 128'(user_rvalid), 128'(1));
    check("t4_user_rdata", user_rdata, {8{16'h0030}});
    check("t4_core_rvalid_off", 128'(core_rvalid), 128'(0));
    to_next();

    // Both requesters reading continuously: C,C,C,C,U repeating, no bubbles.
    drive(1, 0, 16'h0040, 1, 0, 16'h0050, '0);
    for (int i = 0; i < 10; i++) begin
      logic exp_u, prev_c, prev_u;
      exp_u  = (i % 5 == 4);
      prev_c = (i > 0) && ((i - 1) % 5 != 4);
      prev_u = (i > 0) && ((i - 1) % 5 == 4);
      to_neg();
      $display("starve pattern cycle %0d: core_gnt=%0b user_gnt=%0b stall=%0b", i, core_gnt, user_gnt, core_stall);
      check($sformatf("t2_core_gnt_%0d", i), 128'(core_gnt), 128'(!exp_u));
      check($sformatf("t2_user_gnt_%0d", i), 128'(user_gnt), 128'(exp_u));
      check($sformatf("t2_stall_%0d", i), 128'(core_stall), 128'(exp_u));
      check($sformatf("t2_core_rvalid_%0d", i), 128'(core_rvalid), 128'(prev_c));
      check($sformatf("t2_user_rvalid_%0d", i), 128'(user_rvalid), 128'(prev_u));
      to_next();
    end

    // Starve count restarts when user_req drops at count 3.
    for (int i = 0; i < 3; i++) begin
      to_neg();
      check($sformatf("t6_pre_core_gnt_%0d", i), 128'(core_gnt), 128'(1));
      to_next();
    end
    drive(1, 0, 16'h0040, 0, 0, 16'h0050, '0);
    to_neg();
    check("t6_starve_at3", 128'(dut.starve_cnt_reg), 128'(3));
    to_next();
    drive(1, 0, 16'h0040, 1, 0, 16'h0050, '0);
    for (int i = 0; i < 5; i++) begin
      to_neg();
      $display("restart cycle %0d: core_gnt=%0b user_gnt=%0b", i, core_gnt, user_gnt);
      if (i == 0) check("t6_starve_restart", 128'(dut.starve_cnt_reg), 128'(0));
      check($sformatf("t6_core_gnt_%0d", i), 128'(core_gnt), 128'(i != 4));
      check($sformatf("t6_user_gnt_%0d", i), 128'(user_gnt), 128'(i == 4));
      to_next();
    end

    // Core read granted, then reset the following cycle.
    drive(1, 0, 16'h0060, 1, 1, 16'h0070, '0);
    to_neg();
    check("t5_core_gnt", 128'(core_gnt), 128'(1));
    to_next();
    rst = 1'b1;
    drive(0, 0, 16'h0000, 1, 0, 16'h0070, '0);
    to_neg();
    $display("reset after read: core_rvalid=%0b user_gnt=%0b mem_en=%0b", core_rvalid, user_gnt, mem_en);
    check("t5_starve_before", 128'(dut.starve_cnt_reg), 128'(1));
    check("t5_core_rvalid", 128'(core_rvalid), 128'(0));
    check("t5_user_gnt", 128'(user_gnt), 128'(0));
    check("t5_mem_en", 128'(mem_en), 128'(0));
    check("t5_mem_we", 128'(mem_we), 128'(0));
    check("t5_stall", 128'(core_stall), 128'(0));
    to_next();
    rst = 1'b0;
    drive(1, 1, 16'h0080, 0, 0, 16'h0000, '0);
    to_neg();
    check("t5_post_core_rvalid", 128'(core_rvalid), 128'(0));
    check("t5_post_user_rvalid", 128'(user_rvalid), 128'(0));
    check("t5_post_starve", 128'(dut.starve_cnt_reg), 128'(0));
    check("t5_post_core_rdata", core_rdata, '0);
    check("t5_post_user_rdata", user_rdata, '0);
    check("t5_post_core_gnt", 128'(core_gnt), 128'(1));
    to_next();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
